// File: rtl/dwt_haar_inverse_pipelined_top.sv
// Inverse single-level 1-D Haar DWT, pipelined.
// Reconstructs N signed Q8.8 samples from N/2 approximation (cA) and N/2
// detail (cD) coefficients:
//    x[2k]   = ((cA[k] + cD[k]) * COEF) >>> 8
//    x[2k+1] = ((cA[k] - cD[k]) * COEF) >>> 8
// where COEF = 181 is 1/sqrt(2) in Q0.8. Coefficients are captured when a run
// starts, then one pair per cycle is streamed through three register stages
// and written into the output array.
//
// Ports:
//    clk       - clock, all logic on the rising edge
//    rst       - synchronous active-high reset
//    start     - run request, only looked at in IDLE
//    cA_in     - packed approximation coefficients, pair k at [16k +: 16]
//    cD_in     - packed detail coefficients, same packing
//    array_out - reconstructed samples, sample j at [16j +: 16]
//    busy      - high while a run is issuing or draining
//    done      - run complete, held until start is low
module dwt_haar_inverse_pipelined_top #(
   parameter int N    = 8,
   parameter int COEF = 181
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [16*(N/2)-1:0]   cA_in,
   input  logic [16*(N/2)-1:0]   cD_in,
   output logic [16*N-1:0]       array_out,
   output logic                  busy,
   output logic                  done
);

   localparam int P  = N / 2;
   localparam int IW = $clog2(P);
   localparam logic [IW-1:0] LAST_IDX = IW'(P - 1);
   localparam logic [7:0]    COEF_BITS = 8'(COEF);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state, state_next;

   logic [16*P-1:0]  ca_buf, cd_buf;
   logic [IW-1:0]    issue_idx;

   logic                v1, v2, v3;
   logic [IW-1:0]       idx1, idx2, idx3;
   logic signed [15:0]  a, b;
   logic signed [16:0]  s, d;
   logic signed [24:0]  ps, pd;
   logic signed [24:0]  ps_next, pd_next;
   logic signed [24:0]  s_ext, d_ext;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic. DRAIN ends on the edge that writes the last pair,
   // which is recognised by the write stage carrying the final index.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (start) state_next = RUN;
         RUN:   if (issue_idx == LAST_IDX) state_next = DRAIN;
         DRAIN: if (v3 && (idx3 == LAST_IDX)) state_next = DONE;
         DONE:  if (!start) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == RUN) || (state == DRAIN);
   assign done = (state == DONE);

   // Constant multiply as a sum of shifted copies, one term per set bit of
   // COEF (181 = 128+32+16+4+1). The 17-bit operands times an 8-bit constant
   // always fit in 25 signed bits.
   always_comb begin
      s_ext   = {{8{s[16]}}, s};
      d_ext   = {{8{d[16]}}, d};
      ps_next = '0;
      pd_next = '0;
      for (int i = 0; i < 8; i++) begin
         if (COEF_BITS[i]) begin
            ps_next = ps_next + (s_ext <<< i);
            pd_next = pd_next + (d_ext <<< i);
         end
      end
   end

   // Capture, issue, pipeline stages and write-back. Every stage carries its
   // own valid bit and pair index so the write address travels with the data.
   always_ff @(posedge clk) begin
      if (rst) begin
         ca_buf    <= '0;
         cd_buf    <= '0;
         issue_idx <= '0;
         v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
         idx1 <= '0; idx2 <= '0; idx3 <= '0;
         a  <= '0; b  <= '0;
         s  <= '0; d  <= '0;
         ps <= '0; pd <= '0;
         array_out <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            ca_buf    <= cA_in;
            cd_buf    <= cD_in;
            issue_idx <= '0;
         end

         // Stage 1: issue one pair per cycle while in RUN. The counter is
         // held at the last index so it never wraps within a run.
         if (state == RUN) begin
            v1   <= 1'b1;
            idx1 <= issue_idx;
            a    <= ca_buf[{issue_idx, 4'd0} +: 16];
            b    <= cd_buf[{issue_idx, 4'd0} +: 16];
            if (issue_idx != LAST_IDX) issue_idx <= issue_idx + IW'(1);
         end else begin
            v1 <= 1'b0;
         end

         // Stage 2: sum and difference, sign-extended so neither overflows.
         v2   <= v1;
         idx2 <= idx1;
         s    <= {a[15], a} + {b[15], b};
         d    <= {a[15], a} - {b[15], b};

         // Stage 3: scale by 1/sqrt(2).
         v3   <= v2;
         idx3 <= idx2;
         ps   <= ps_next;
         pd   <= pd_next;

         // Write: taking bits [23:8] is a floor shift by 8 that wraps to 16 bits.
         if (v3) begin
            array_out[{idx3, 5'd0}  +: 16] <= ps[23:8];
            array_out[{idx3, 5'd16} +: 16] <= pd[23:8];
         end
      end
   end

endmodule

// File: tb/tb_dwt_haar_inverse_pipelined_top.sv
// Self-checking bench for dwt_haar_inverse_pipelined_top (N = 8).
// Table-driven runs with hand-computed results, followed by hand-written
// sequences for input capture, start held through DONE and a mid-run reset.
module tb_dwt_haar_inverse_pipelined_top;

   localparam int N = 8;
   localparam int P = N / 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [16*P-1:0]   ca_in, cd_in;
   logic [16*N-1:0]   array_out;
   logic              busy, done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string           name;
      logic [16*P-1:0] ca;
      logic [16*P-1:0] cd;
      logic [16*N-1:0] expect_out;
   } vec_t;

   vec_t vecs[4];

   dwt_haar_inverse_pipelined_top #(.N(N), .COEF(181)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cA_in     (ca_in),
      .cD_in     (cd_in),
      .array_out (array_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Compare one value and log a failure line if it differs.
   task automatic check_output(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a run and wait (bounded) for done. Returns the number of edges
   // from E0 to the edge where done rose, and how many of those samples
   // (after E0..E(n-1)) saw busy high. start stays high if hold is set.
   task automatic apply_stimulus(input logic [16*P-1:0] ca, input logic [16*P-1:0] cd,
                                 input bit hold, output int edges, output int busy_cnt);
      ca_in = ca;
      cd_in = cd;
      start = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      edges    = 0;
      busy_cnt = 0;
      while (!done && edges < 40) begin
         if (busy) busy_cnt++;
         tick();
         edges++;
      end
   endtask

   initial begin
      int edges, busy_cnt;

      vecs[0].name = "unity_approx";
      vecs[0].ca   = {4{16'h0100}};
      vecs[0].cd   = '0;
      vecs[0].expect_out = {8{16'h00B5}};

      vecs[1].name = "signed_detail";
      vecs[1].ca   = '0;
      vecs[1].cd   = {48'h0, 16'h0100};
      vecs[1].expect_out = {96'h0, 16'hFF4B, 16'h00B5};

      vecs[2].name = "round_trip";
      vecs[2].ca   = {4{16'h016A}};
      vecs[2].cd   = '0;
      vecs[2].expect_out = {8{16'h00FF}};

      vecs[3].name = "wrap_overflow";
      vecs[3].ca   = {16'h7FFF, 48'h0};
      vecs[3].cd   = {16'h7FFF, 48'h0};
      vecs[3].expect_out = {16'h0000, 16'hB4FE, 96'h0};

      rst   = 1'b1;
      start = 1'b0;
      ca_in = '0;
      cd_in = '0;
      tick();
      tick();
      rst = 1'b0;
      check_output("reset_array", 128'(array_out), 128'h0);
      check_output("reset_busy",  128'(busy), 128'h0);
      check_output("reset_done",  128'(done), 128'h0);
      tick();
      check_output("idle_no_start_busy", 128'(busy), 128'h0);

      for (int i = 0; i < 4; i++) begin
         apply_stimulus(vecs[i].ca, vecs[i].cd, 1'b0, edges, busy_cnt);
         check_output({vecs[i].name, "_done_edges"}, 128'(edges), 128'd7);
         check_output({vecs[i].name, "_busy_edges"}, 128'(busy_cnt), 128'd7);
         check_output({vecs[i].name, "_busy_low"}, 128'(busy), 128'h0);
         check_output({vecs[i].name, "_out"}, 128'(array_out), 128'(vecs[i].expect_out));
         tick();
         check_output({vecs[i].name, "_done_clear"}, 128'(done), 128'h0);
      end

      // Inputs scrambled right after E0, start held through DONE.
      ca_in = {4{16'h0100}};
      cd_in = '0;
      start = 1'b1;
      tick();
      ca_in = {4{16'h1234}};
      cd_in = {4{16'hABCD}};
      edges = 0;
      while (!done && edges < 40) begin
         tick();
         edges++;
      end
      check_output("capture_edges", 128'(edges), 128'd7);
      check_output("capture_out", 128'(array_out), 128'({8{16'h00B5}}));
      for (int i = 0; i < 4; i++) begin
         tick();
         check_output("hold_done_high", 128'(done), 128'h1);
         check_output("hold_no_restart", 128'(busy), 128'h0);
      end
      start = 1'b0;
      tick();
      check_output("drop_start_done", 128'(done), 128'h0);
      check_output("drop_start_busy", 128'(busy), 128'h0);
      tick();
      check_output("idle_stays_idle", 128'(busy), 128'h0);
      check_output("idle_out_kept", 128'(array_out), 128'({8{16'h00B5}}));

      // Reset sampled at E3 of a run: everything clears and nothing is written.
      ca_in = {4{16'h016A}};
      cd_in = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_output("midrst_array", 128'(array_out), 128'h0);
      check_output("midrst_busy",  128'(busy), 128'h0);
      check_output("midrst_done",  128'(done), 128'h0);
      for (int i = 0; i < 6; i++) tick();
      check_output("midrst_no_writes", 128'(array_out), 128'h0);
      check_output("midrst_still_idle", 128'(busy), 128'h0);

      apply_stimulus(vecs[1].ca, vecs[1].cd, 1'b0, edges, busy_cnt);
      check_output("after_rst_edges", 128'(edges), 128'd7);
      check_output("after_rst_out", 128'(array_out), 128'(vecs[1].expect_out));
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
